// File: rtl/vector_mul_add.sv
// Multi-channel fixed-point dot-product engine: per-beat multiply + registered adder tree,
// cross-beat accumulation, bias or batch-norm, round-half-up requantize, optional ReLU, saturate.
module vector_mul_add #(
  parameter int CPF          = 32,
  parameter int DATA_CHANNEL = 2,
  parameter int DIN_DW       = 8,
  parameter int DIN_Q        = 2,
  parameter int WW           = 8,
  parameter int Q            = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int BIAS_DW      = 4,
  parameter int BN           = 0,
  parameter int BN_SCALE_Q   = 13,
  parameter int BN_BIAS_Q    = 13,
  parameter int MID_Q        = 12,
  parameter int DOUT_DW      = 8,
  parameter int DOUT_Q       = 1,
  parameter int RELU         = 0,
  localparam int BW          = (BN != 0) ? 2 * BIAS_DW : BIAS_DW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              op_din_en,
  input  logic                              op_din_eop,
  input  logic [DIN_DW*CPF-1:0]             op_din,
  input  logic [WW*DATA_CHANNEL*CPF-1:0]    op_weight,
  input  logic [BW*DATA_CHANNEL-1:0]        op_bias,
  output logic [DOUT_DW*DATA_CHANNEL-1:0]   op_dout,
  output logic                              op_dout_en
);

  localparam int LEVELS = $clog2(CPF);
  localparam int NP     = 1 << LEVELS;
  localparam int P      = DIN_Q + Q;
  localparam int S1     = P - MID_Q;
  localparam int S1L    = (S1 < 0) ? -S1 : 0;
  localparam int SHB    = MID_Q + BN_SCALE_Q - BN_BIAS_Q;
  localparam int SHB_L  = (SHB > 0) ? SHB : 0;
  localparam int RES_Q  = (BN != 0) ? MID_Q + BN_SCALE_Q : P;
  localparam int S2     = RES_Q - DOUT_Q;
  localparam int S2L    = (S2 < 0) ? -S2 : 0;
  localparam int S2R    = (S2 > 0) ? S2 : 0;
  localparam int S2H    = (S2R > 0) ? S2R - 1 : 0;
  localparam int RES_W  = ACC_WIDTH + 2 * BIAS_DW + S1L + SHB_L + S2L + 2;

  localparam logic signed [RES_W-1:0] RND2    = (S2R > 0) ? (RES_W'(1) << S2H) : RES_W'(0);
  localparam logic signed [RES_W-1:0] OUT_MAX = RES_W'((1 << (DOUT_DW - 1)) - 1);
  localparam logic signed [RES_W-1:0] OUT_MIN = -OUT_MAX - RES_W'(1);

  function automatic logic signed [BIAS_DW-1:0] field(input logic [BW*DATA_CHANNEL-1:0] v,
                                                      input int idx);
    return v[idx*BIAS_DW +: BIAS_DW];
  endfunction

  function automatic logic [DOUT_DW-1:0] requant(input logic signed [RES_W-1:0] x);
    logic signed [RES_W-1:0] r;
    // NOTE: temporaries inside a function are plain variables, so blocking '=' is correct here.
    r = ((x + RND2) >>> S2R) <<< S2L;
    if (RELU != 0 && r < 0) r = '0;
    if (r > OUT_MAX)      r = OUT_MAX;
    else if (r < OUT_MIN) r = OUT_MIN;
    return r[DOUT_DW-1:0];
  endfunction

  // Input capture stage
  logic                       in_en, in_eop;
  logic signed [DIN_DW-1:0]   din_q [CPF];
  logic signed [WW-1:0]       w_q   [DATA_CHANNEL][CPF];
  logic [BW*DATA_CHANNEL-1:0] bias_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_en  <= 1'b0;
      in_eop <= 1'b0;
      bias_q <= '0;
      for (int i = 0; i < CPF; i++) begin
        din_q[i] <= '0;
        for (int c = 0; c < DATA_CHANNEL; c++) w_q[c][i] <= '0;
      end
    end else begin
      in_en  <= op_din_en;
      in_eop <= op_din_eop;
      bias_q <= op_bias;
      for (int i = 0; i < CPF; i++) begin
        din_q[i] <= op_din[i*DIN_DW +: DIN_DW];
        for (int c = 0; c < DATA_CHANNEL; c++) w_q[c][i] <= op_weight[(c*CPF+i)*WW +: WW];
      end
    end
  end

  // Heap-ordered tree: leaves NP..2NP-1 hold products, node k sums 2k and 2k+1, root is node 1.
  logic signed [ACC_WIDTH-1:0] node [DATA_CHANNEL][1:2*NP-1];
  logic [LEVELS:0]             v_pipe, e_pipe;
  logic [BW*DATA_CHANNEL-1:0]  b_pipe [LEVELS+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_pipe <= '0;
      e_pipe <= '0;
      for (int l = 0; l <= LEVELS; l++) b_pipe[l] <= '0;
      // NOTE: the tree arrays are reset too, so an aborted vector leaves nothing behind in flight.
      for (int c = 0; c < DATA_CHANNEL; c++)
        for (int k = 1; k < 2 * NP; k++) node[c][k] <= '0;
    end else begin
      v_pipe[0] <= in_en;
      e_pipe[0] <= in_eop;
      b_pipe[0] <= bias_q;
      for (int l = 1; l <= LEVELS; l++) begin
        v_pipe[l] <= v_pipe[l-1];
        e_pipe[l] <= e_pipe[l-1];
        b_pipe[l] <= b_pipe[l-1];
      end
      for (int c = 0; c < DATA_CHANNEL; c++) begin
        for (int i = 0; i < CPF; i++)
          node[c][NP+i] <= ACC_WIDTH'(din_q[i]) * ACC_WIDTH'(w_q[c][i]);
        for (int i = CPF; i < NP; i++) node[c][NP+i] <= '0;
        for (int k = 1; k < NP; k++) node[c][k] <= node[c][2*k] + node[c][2*k+1];
      end
    end
  end

  // Accumulator: first beat of a vector loads, later beats add, wrapping at ACC_WIDTH.
  logic signed [ACC_WIDTH-1:0] acc [DATA_CHANNEL];
  logic                        first, acc_done;
  logic [BW*DATA_CHANNEL-1:0]  acc_bias;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first    <= 1'b1;
      acc_done <= 1'b0;
      acc_bias <= '0;
      for (int c = 0; c < DATA_CHANNEL; c++) acc[c] <= '0;
    end else begin
      acc_done <= v_pipe[LEVELS] & e_pipe[LEVELS];
      if (v_pipe[LEVELS]) begin
        first <= e_pipe[LEVELS];
        for (int c = 0; c < DATA_CHANNEL; c++)
          acc[c] <= first ? node[c][1] : acc[c] + node[c][1];
        if (e_pipe[LEVELS]) acc_bias <= b_pipe[LEVELS];
      end
    end
  end

  logic signed [RES_W-1:0] res_q [DATA_CHANNEL];
  logic                    res_v;

  generate
    if (BN == 0) begin : g_bias
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          res_v <= 1'b0;
          for (int c = 0; c < DATA_CHANNEL; c++) res_q[c] <= '0;
        end else begin
          res_v <= acc_done;
          for (int c = 0; c < DATA_CHANNEL; c++)
            res_q[c] <= RES_W'(acc[c]) + RES_W'(field(acc_bias, c));
        end
      end
    end else begin : g_bn
      localparam int S1R   = (S1 > 0) ? S1 : 0;
      localparam int S1H   = (S1R > 0) ? S1R - 1 : 0;
      localparam int SHB_R = (SHB < 0) ? -SHB : 0;
      localparam logic signed [RES_W-1:0] RND1 = (S1R > 0) ? (RES_W'(1) << S1H) : RES_W'(0);

      logic signed [RES_W-1:0]    mid_q [DATA_CHANNEL];
      logic                       mid_v;
      logic [BW*DATA_CHANNEL-1:0] mid_bias;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mid_v    <= 1'b0;
          mid_bias <= '0;
          res_v    <= 1'b0;
          for (int c = 0; c < DATA_CHANNEL; c++) begin
            mid_q[c] <= '0;
            res_q[c] <= '0;
          end
        end else begin
          mid_v    <= acc_done;
          mid_bias <= acc_bias;
          res_v    <= mid_v;
          for (int c = 0; c < DATA_CHANNEL; c++) begin
            mid_q[c] <= ((RES_W'(acc[c]) + RND1) >>> S1R) <<< S1L;
            // Field 2c+1 is the scale, field 2c the bias of channel c.
            res_q[c] <= mid_q[c] * RES_W'(field(mid_bias, 2 * c + 1))
                      + ((RES_W'(field(mid_bias, 2 * c)) <<< SHB_L) >>> SHB_R);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_dout_en <= 1'b0;
      op_dout    <= '0;
    end else begin
      op_dout_en <= res_v;
      if (res_v)
        for (int c = 0; c < DATA_CHANNEL; c++)
          op_dout[c*DOUT_DW +: DOUT_DW] <= requant(res_q[c]);
    end
  end

endmodule

// File: tb/tb_vector_mul_add.sv
// Directed bench for vector_mul_add: default instance plus a RELU=1 instance on shared stimulus,
// expected values hand-computed from the fixed-point arithmetic.
module tb_vector_mul_add;

  localparam int CPF = 32;
  localparam int DC  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              eop = 1'b0;
  logic [8*CPF-1:0]  din    = '0;
  logic [8*DC*CPF-1:0] weight = '0;
  logic [4*DC-1:0]   bias   = '0;
  logic [8*DC-1:0]   dout, dout_r;
  logic              dout_en, dout_en_r;

  int total = 0;
  int bad   = 0;

  int           n_p;
  int           p_lat [4];
  logic [15:0]  p_d   [4];
  logic [15:0]  p_dr  [4];

  always #5 clk = ~clk;

  vector_mul_add dut (
    .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
    .op_weight(weight), .op_bias(bias), .op_dout(dout), .op_dout_en(dout_en));

  vector_mul_add #(.RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
    .op_weight(weight), .op_bias(bias), .op_dout(dout_r), .op_dout_en(dout_en_r));

  function automatic logic signed [7:0] ch(input logic [15:0] v, input int c);
    return v[c*8 +: 8];
  endfunction

  task automatic set_data(input logic [7:0] d, input logic [7:0] w0, input logic [7:0] w1,
                          input int n);
    for (int i = 0; i < CPF; i++) begin
      din[i*8 +: 8]            = (i < n) ? d  : 8'd0;
      weight[i*8 +: 8]         = (i < n) ? w0 : 8'd0;
      weight[(CPF+i)*8 +: 8]   = (i < n) ? w1 : 8'd0;
    end
  endtask

  // Drives en/eop on a falling edge; the caller loads data right after, before the sampling edge.
  task automatic beat(input logic e);
    @(negedge clk);
    en  = 1'b1;
    eop = e;
  endtask

  task automatic idle();
    @(negedge clk);
    en  = 1'b0;
    eop = 1'b0;
  endtask

  // Records every result strobe; latency counts rising edges after the last beat's sampling edge.
  task automatic collect(input int window);
    n_p = 0;
    for (int j = 0; j < 4; j++) begin
      p_lat[j] = -1;
      p_d[j]   = '0;
      p_dr[j]  = '0;
    end
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == 1) begin
        en  = 1'b0;
        eop = 1'b0;
      end
      if (dout_en) begin
        if (n_p < 4) begin
          p_lat[n_p] = k - 1;
          p_d[n_p]   = dout;
          p_dr[n_p]  = dout_r;
        end
        n_p++;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL reset_dout: got %h want 0000", dout); end
    total++; if (dout_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", dout_en); end
    total++; if (dout_en_r !== 1'b0 || dout_r !== 16'h0000) begin
      bad++; $display("FAIL reset_relu: got en=%b dout=%h want 0/0000", dout_en_r, dout_r); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bias = '0;
    beat(1'b1); set_data(8'd4, 8'd64, 8'd64, CPF);
    collect(14);
    total++; if (n_p !== 1) begin bad++; $display("FAIL basic_pulses: got %0d want 1", n_p); end
    total++; if (p_lat[0] !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", p_lat[0]); end
    total++; if (ch(p_d[0], 0) !== 8'sd16) begin bad++; $display("FAIL basic_ch0: got %0d want 16", ch(p_d[0], 0)); end
    total++; if (ch(p_d[0], 1) !== 8'sd16) begin bad++; $display("FAIL basic_ch1: got %0d want 16", ch(p_d[0], 1)); end
    total++; if (ch(dout, 0) !== 8'sd16) begin bad++; $display("FAIL basic_hold: got %0d want 16", ch(dout, 0)); end
  endtask

  task automatic test_saturate();
    beat(1'b1); set_data(8'd127, 8'd127, 8'd127, CPF);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd127) begin bad++; $display("FAIL sat_pos_ch0: got %0d want 127", ch(p_d[0], 0)); end
    total++; if (ch(p_d[0], 1) !== 8'sd127) begin bad++; $display("FAIL sat_pos_ch1: got %0d want 127", ch(p_d[0], 1)); end
    beat(1'b1); set_data(8'd127, -8'sd127, -8'sd127, CPF);
    collect(12);
    total++; if (ch(p_d[0], 0) !== -8'sd128) begin bad++; $display("FAIL sat_neg_ch0: got %0d want -128", ch(p_d[0], 0)); end
    total++; if (ch(p_d[0], 1) !== -8'sd128) begin bad++; $display("FAIL sat_neg_ch1: got %0d want -128", ch(p_d[0], 1)); end
  endtask

  task automatic test_rounding();
    // raw 256 -> +0.5 LSB rounds up to 1
    beat(1'b1); set_data(8'd4, 8'd64, 8'd64, 1);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd1) begin bad++; $display("FAIL round_half_ch0: got %0d want 1", ch(p_d[0], 0)); end
    total++; if (ch(p_d[0], 1) !== 8'sd1) begin bad++; $display("FAIL round_half_ch1: got %0d want 1", ch(p_d[0], 1)); end
    // raw 255 -> just below half, 0
    beat(1'b1); set_data(8'd3, 8'd85, 8'd85, 1);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd0) begin bad++; $display("FAIL round_below_ch0: got %0d want 0", ch(p_d[0], 0)); end
    // raw 256 + bias -1 (sign-extended) = 255 -> 0
    bias = 8'hFF;
    beat(1'b1); set_data(8'd4, 8'd64, 8'd64, 1);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd0) begin bad++; $display("FAIL bias_neg_ch0: got %0d want 0", ch(p_d[0], 0)); end
    total++; if (ch(p_d[0], 1) !== 8'sd0) begin bad++; $display("FAIL bias_neg_ch1: got %0d want 0", ch(p_d[0], 1)); end
    // raw 255 + bias +1 = 256 -> 1
    bias = 8'h11;
    beat(1'b1); set_data(8'd3, 8'd85, 8'd85, 1);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd1) begin bad++; $display("FAIL bias_pos_ch0: got %0d want 1", ch(p_d[0], 0)); end
    bias = '0;
  endtask

  task automatic test_two_beat();
    beat(1'b0); set_data(8'd4, 8'd64, 8'd64, CPF);
    beat(1'b1);
    collect(14);
    total++; if (n_p !== 1) begin bad++; $display("FAIL two_beat_pulses: got %0d want 1", n_p); end
    total++; if (p_lat[0] !== 9) begin bad++; $display("FAIL two_beat_latency: got %0d want 9", p_lat[0]); end
    total++; if (ch(p_d[0], 0) !== 8'sd32 || ch(p_d[0], 1) !== 8'sd32) begin
      bad++; $display("FAIL two_beat_value: got %0d/%0d want 32/32", ch(p_d[0], 0), ch(p_d[0], 1)); end
    beat(1'b0);
    idle();
    beat(1'b1);
    collect(14);
    total++; if (n_p !== 1) begin bad++; $display("FAIL gap_pulses: got %0d want 1", n_p); end
    total++; if (ch(p_d[0], 0) !== 8'sd32 || ch(p_d[0], 1) !== 8'sd32) begin
      bad++; $display("FAIL gap_value: got %0d/%0d want 32/32", ch(p_d[0], 0), ch(p_d[0], 1)); end
  endtask

  task automatic test_relu();
    beat(1'b1); set_data(8'd4, 8'd64, -8'sd64, CPF);
    collect(12);
    total++; if (ch(p_d[0], 0) !== 8'sd16 || ch(p_d[0], 1) !== -8'sd16) begin
      bad++; $display("FAIL mixed_sign: got %0d/%0d want 16/-16", ch(p_d[0], 0), ch(p_d[0], 1)); end
    total++; if (ch(p_dr[0], 0) !== 8'sd16 || ch(p_dr[0], 1) !== 8'sd0) begin
      bad++; $display("FAIL relu_clamp: got %0d/%0d want 16/0", ch(p_dr[0], 0), ch(p_dr[0], 1)); end
  endtask

  task automatic test_back_to_back();
    beat(1'b1); set_data(8'd4, 8'd64, 8'd64, CPF);
    beat(1'b1); set_data(8'd4, 8'd32, 8'd32, CPF);
    collect(14);
    total++; if (n_p !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", n_p); end
    total++; if (p_lat[0] !== 8 || p_lat[1] !== 9) begin
      bad++; $display("FAIL b2b_timing: got %0d,%0d want 8,9", p_lat[0], p_lat[1]); end
    total++; if (ch(p_d[0], 0) !== 8'sd16) begin bad++; $display("FAIL b2b_first: got %0d want 16", ch(p_d[0], 0)); end
    total++; if (ch(p_d[1], 1) !== 8'sd8) begin bad++; $display("FAIL b2b_second: got %0d want 8", ch(p_d[1], 1)); end
  endtask

  task automatic test_abort();
    beat(1'b0); set_data(8'd4, 8'd64, 8'd64, CPF);
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL abort_reset_dout: got %h want 0000", dout); end
    rst = 1'b1;
    beat(1'b1);
    collect(14);
    total++; if (n_p !== 1) begin bad++; $display("FAIL abort_pulses: got %0d want 1", n_p); end
    total++; if (p_lat[0] !== 9) begin bad++; $display("FAIL abort_latency: got %0d want 9", p_lat[0]); end
    total++; if (ch(p_d[0], 0) !== 8'sd16 || ch(p_d[0], 1) !== 8'sd16) begin
      bad++; $display("FAIL abort_value: got %0d/%0d want 16/16", ch(p_d[0], 0), ch(p_d[0], 1)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_two_beat();
    test_relu();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
